// File: rtl/spi_pkg.sv
// Shared definitions for the Motorola-format SPI target and its master-side wrapper.
package spi_pkg;

  // Positions of the polarity and phase bits within the SPI mode number.
  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  // Frame-size limits supported by both ends of the link.
  localparam int unsigned FRAME_SIZE_MIN = 4;
  localparam int unsigned FRAME_SIZE_MAX = 32;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Synchroniser for one asynchronous SPI pin, followed by a rise/fall detector.
module spi_in_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  last_q;

  // Shift the pin through the synchroniser and remember the previous synced level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetVal}};
      last_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      last_q <= sync_q[SyncStages-1];
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = level_o & ~last_q;
  assign fall_o  = ~level_o & last_q;

endmodule

// File: rtl/spi_mot_target.sv
// Motorola-format SPI target: oversampled pins, FSM, bit counter, shift and holding registers.
module spi_mot_target
  import spi_pkg::*;
#(
  parameter int unsigned CFG_MOT_MODE   = 3,
  parameter int unsigned CFG_FRAME_SIZE = 8,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                      PCLK,
  input  logic                      PRESETN,
  input  logic                      SPICLKI,
  input  logic                      SPISSI,
  input  logic                      SPISDI,
  output logic                      SPISDO,
  output logic                      SPIOEN,
  input  logic [CFG_FRAME_SIZE-1:0] TX_DATA,
  input  logic                      TX_VALID,
  output logic                      TX_READY,
  output logic [CFG_FRAME_SIZE-1:0] RX_DATA,
  output logic                      RX_VALID,
  input  logic                      RX_READY,
  output logic                      TX_UNDERRUN,
  output logic                      RX_OVERFLOW,
  output logic                      FRAME_ABORT
);

  localparam int unsigned N    = CFG_FRAME_SIZE;
  localparam int unsigned CntW = $clog2(N);
  localparam logic [1:0]  Mode = CFG_MOT_MODE[1:0];
  localparam logic        Cpol = Mode[CPOL_BIT];
  localparam logic        Cpha = Mode[CPHA_BIT];

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic sdi_lvl, sdi_rise, sdi_fall;

  spi_in_sync #(.SyncStages(SYNC_STAGES), .ResetVal(Cpol)) u_sync_sclk (
    .clk_i  (PCLK),
    .rst_ni (PRESETN),
    .d_i    (SPICLKI),
    .level_o(sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .clk_i  (PCLK),
    .rst_ni (PRESETN),
    .d_i    (SPISSI),
    .level_o(ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_in_sync #(.SyncStages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sdi (
    .clk_i  (PCLK),
    .rst_ni (PRESETN),
    .d_i    (SPISDI),
    .level_o(sdi_lvl),
    .rise_o (sdi_rise),
    .fall_o (sdi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, ss_lvl, sdi_rise, sdi_fall};

  // Lead edge leaves the idle level; CPHA picks which edge samples and which shifts.
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = Cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = Cpol ? sclk_rise : sclk_fall;
  assign sample_edge = Cpha ? trail_edge : lead_edge;
  assign shift_edge  = Cpha ? lead_edge : trail_edge;

  spi_state_e      state_q, state_d;
  logic [CntW-1:0] bitcnt_q, bitcnt_d;
  logic [N-1:0]    rx_shift_q, rx_shift_d;
  logic [N-1:0]    tx_shift_q, tx_shift_d;
  logic [N-1:0]    tx_hold_q, tx_hold_d;
  logic            tx_full_q, tx_full_d;
  logic [N-1:0]    rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            sdo_q, sdo_d;
  logic            oen_q, oen_d;
  // Back-to-back frame waiting for its first shift edge to load and present.
  logic            pend_q, pend_d;
  logic            underrun_q, underrun_d;
  logic            overflow_q, overflow_d;
  logic            abort_q, abort_d;

  logic            frame_start, start_present, frame_done;
  logic [N-1:0]    rx_word, start_word;

  // State register for FSM, datapath and pulse outputs.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= StIdle;
      bitcnt_q   <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sdo_q      <= 1'b0;
      oen_q      <= 1'b0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sdo_q      <= sdo_d;
      oen_q      <= oen_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      abort_q    <= abort_d;
    end
  end

  // Next-state logic: frame sequencing, shifting and both handshakes.
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    tx_full_d     = tx_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    sdo_d         = sdo_q;
    oen_d         = oen_q;
    pend_d        = pend_q;
    underrun_d    = 1'b0;
    overflow_d    = 1'b0;
    abort_d       = 1'b0;
    frame_start   = 1'b0;
    start_present = 1'b0;
    frame_done    = 1'b0;
    rx_word       = {rx_shift_q[N-2:0], sdi_lvl};
    start_word    = tx_full_q ? tx_hold_q : '0;

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d       = StActive;
          oen_d         = 1'b1;
          bitcnt_d      = '0;
          pend_d        = 1'b0;
          frame_start   = 1'b1;
          // CPHA=0 must have the first bit on the line before the first edge.
          start_present = ~Cpha;
        end
      end
      StActive: begin
        if (ss_rise) begin
          // SS wins over any edge seen in the same cycle.
          state_d  = StIdle;
          oen_d    = 1'b0;
          sdo_d    = 1'b0;
          pend_d   = 1'b0;
          bitcnt_d = '0;
          abort_d  = (bitcnt_q != '0);
        end else begin
          if (sample_edge) begin
            rx_shift_d = rx_word;
            if (bitcnt_q == CntW'(N - 1)) begin
              bitcnt_d   = '0;
              frame_done = 1'b1;
              pend_d     = 1'b1;
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
          if (shift_edge) begin
            if (pend_q) begin
              frame_start   = 1'b1;
              start_present = 1'b1;
              pend_d        = 1'b0;
            end else begin
              sdo_d      = tx_shift_q[N-1];
              tx_shift_d = {tx_shift_q[N-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (frame_start) begin
      underrun_d = ~tx_full_q;
      tx_full_d  = 1'b0;
      if (start_present) begin
        sdo_d      = start_word[N-1];
        tx_shift_d = {start_word[N-2:0], 1'b0};
      end else begin
        tx_shift_d = start_word;
      end
    end

    // A load coinciding with an empty-holding start fills holding for the next frame.
    if (TX_VALID && !tx_full_q) begin
      tx_hold_d = TX_DATA;
      tx_full_d = 1'b1;
    end

    if (rx_valid_q && RX_READY) begin
      rx_valid_d = 1'b0;
    end
    if (frame_done) begin
      if (!rx_valid_q || RX_READY) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  assign SPISDO      = sdo_q;
  assign SPIOEN      = oen_q;
  assign TX_READY    = ~tx_full_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_UNDERRUN = underrun_q;
  assign RX_OVERFLOW = overflow_q;
  assign FRAME_ABORT = abort_q;

endmodule

// File: tb/tb_spi_mot_target.sv
// Bench: one target per SPI mode on a shared bus; mode 3 is checked against a frame-level model.
module tb_spi_mot_target;

  localparam int H = 4;  // SCLK half-period in PCLK cycles

  logic pclk = 1'b0;
  logic presetn;
  logic sclk_base, ss, mosi0, mosi1;
  logic [7:0] tx_data, aux_data;
  logic tx_valid, aux_valid, rx_ready;

  logic sdo [4];
  logic oen [4];
  logic txr [4];
  logic rxv [4];
  logic und [4];
  logic ovf [4];
  logic abt [4];
  logic [7:0] rxd [4];

  always #5 pclk = ~pclk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    localparam logic Cpol = (m >= 2);
    localparam logic Cpha = (m % 2 == 1);
    spi_mot_target #(
      .CFG_MOT_MODE  (m),
      .CFG_FRAME_SIZE(8),
      .SYNC_STAGES   (2)
    ) u_dut (
      .PCLK       (pclk),
      .PRESETN    (presetn),
      .SPICLKI    (sclk_base ^ Cpol),
      .SPISSI     (ss),
      .SPISDI     (Cpha ? mosi1 : mosi0),
      .SPISDO     (sdo[m]),
      .SPIOEN     (oen[m]),
      .TX_DATA    ((m == 3) ? tx_data : aux_data),
      .TX_VALID   ((m == 3) ? tx_valid : aux_valid),
      .TX_READY   (txr[m]),
      .RX_DATA    (rxd[m]),
      .RX_VALID   (rxv[m]),
      .RX_READY   ((m == 3) ? rx_ready : 1'b1),
      .TX_UNDERRUN(und[m]),
      .RX_OVERFLOW(ovf[m]),
      .FRAME_ABORT(abt[m])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed pulses and RX handshakes of the mode-3 target.
  int n_und = 0, n_ovf = 0, n_abt = 0;
  logic [7:0] got_q[$];
  always @(posedge pclk) begin
    if (und[3]) n_und <= n_und + 1;
    if (ovf[3]) n_ovf <= n_ovf + 1;
    if (abt[3]) n_abt <= n_abt + 1;
    if (rxv[3] && rx_ready) got_q.push_back(rxd[3]);
  end

  // TX feeder: hands queued words to the mode-3 target whenever it is ready.
  logic [7:0] feed_q[$];
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge pclk);
      if (tx_valid) tx_valid = 1'b0;
      else if (feed_q.size() > 0 && txr[3] && presetn) begin
        tx_data  = feed_q.pop_front();
        tx_valid = 1'b1;
      end
    end
  end

  // Reference model state: words owned by the target in send order, and RX bookkeeping.
  logic [7:0] mq[$];
  logic [7:0] exp_got[$];
  int exp_und = 0, exp_ovf = 0, exp_abt = 0;
  logic exp_pend = 1'b0;
  logic [7:0] exp_pend_data = 8'h00;

  logic [7:0] mosi_w [4];
  logic [7:0] cap [4][4];
  logic oen_mid;

  task automatic push_tx(input logic [7:0] w);
    feed_q.push_back(w);
    mq.push_back(w);
  endtask

  task automatic set_rx_ready(input logic v);
    rx_ready = v;
    if (v && exp_pend) begin
      exp_got.push_back(exp_pend_data);
      exp_pend = 1'b0;
    end
    repeat (3) @(negedge pclk);
  endtask

  // One bit: idle half with CPHA=0 data, lead edge, active half, trail edge.
  task automatic do_bit(input int f, input int b, input logic v);
    mosi0 = v;
    repeat (H) @(negedge pclk);
    for (int k = 0; k < 4; k += 2) cap[k][f][7-b] = sdo[k];
    if (f == 0 && b == 0) oen_mid = oen[3];
    sclk_base = 1'b1;
    mosi1 = v;
    repeat (H) @(negedge pclk);
    for (int k = 1; k < 4; k += 2) cap[k][f][7-b] = sdo[k];
    sclk_base = 1'b0;
  endtask

  task automatic burst(input int nfr, input int part);
    ss = 1'b0;
    repeat (H) @(negedge pclk);
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < 8; b++) do_bit(f, b, mosi_w[f][7-b]);
    for (int b = 0; b < part; b++) do_bit(nfr, b, mosi_w[nfr][7-b]);
    repeat (H) @(negedge pclk);
    ss = 1'b1;
    repeat (2 * H) @(negedge pclk);
  endtask

  // Predict one SS-low burst at frame level, drive it, then compare the mode-3 target.
  task automatic run(input int nfr, input int part);
    logic [7:0] exp_miso [4];
    int starts;
    starts = nfr + ((part > 0) ? 1 : 0);
    for (int s = 0; s < starts; s++) begin
      if (mq.size() > 0) exp_miso[s] = mq.pop_front();
      else begin
        exp_miso[s] = 8'h00;
        exp_und++;
      end
    end
    for (int f = 0; f < nfr; f++) begin
      if (rx_ready) exp_got.push_back(mosi_w[f]);
      else if (!exp_pend) begin
        exp_pend = 1'b1;
        exp_pend_data = mosi_w[f];
      end else exp_ovf++;
    end
    if (part > 0) exp_abt++;
    oen_mid = 1'b0;
    burst(nfr, part);
    for (int f = 0; f < nfr; f++) check_eq($sformatf("miso_f%0d", f), cap[3][f], exp_miso[f]);
    check_eq("rx_count", got_q.size(), exp_got.size());
    for (int i = 0; i < got_q.size() && i < exp_got.size(); i++)
      check_eq($sformatf("rx_word%0d", i), got_q[i], exp_got[i]);
    got_q.delete();
    exp_got.delete();
    check_eq("underruns", n_und, exp_und);
    check_eq("overflows", n_ovf, exp_ovf);
    check_eq("aborts", n_abt, exp_abt);
    check_eq("rx_valid", rxv[3], exp_pend);
    if (exp_pend) check_eq("rx_data_held", rxd[3], exp_pend_data);
    check_eq("oen_active", oen_mid, 1'b1);
    check_eq("oen_after", oen[3], 1'b0);
    check_eq("tx_ready_after", txr[3], (mq.size() == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_sdo"}, sdo[k], 1'b0);
      check_eq({tag, "_oen"}, oen[k], 1'b0);
      check_eq({tag, "_txr"}, txr[k], 1'b1);
      check_eq({tag, "_rxv"}, rxv[k], 1'b0);
      check_eq({tag, "_rxd"}, rxd[k], 8'h00);
      check_eq({tag, "_pulses"}, {und[k], ovf[k], abt[k]}, 3'b000);
    end
  endtask

  initial begin
    presetn   = 1'b0;
    sclk_base = 1'b0;
    ss        = 1'b1;
    mosi0     = 1'b0;
    mosi1     = 1'b0;
    aux_data  = 8'h00;
    aux_valid = 1'b0;
    rx_ready  = 1'b0;
    repeat (3) @(negedge pclk);
    check_reset_outputs("reset");
    presetn = 1'b1;
    repeat (3) @(negedge pclk);

    // Same 0xA5 / 0x3C exchange through every mode.
    push_tx(8'hA5);
    aux_data  = 8'hA5;
    aux_valid = 1'b1;
    @(negedge pclk);
    aux_valid = 1'b0;
    repeat (4) @(negedge pclk);
    mosi_w[0] = 8'h3C;
    run(1, 0);
    check_eq("mode3_rx_data", rxd[3], 8'h3C);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("mode%0d_miso", k), cap[k][0], 8'hA5);
      check_eq($sformatf("mode%0d_rx_data", k), rxd[k], 8'h3C);
    end
    check_eq("mode0_msb_pre_edge", cap[0][0][7], 1'b1);
    check_eq("mode2_msb_pre_edge", cap[2][0][7], 1'b1);

    // Back-to-back frames, TX refilled as soon as holding empties.
    set_rx_ready(1'b1);
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    repeat (4) @(negedge pclk);
    mosi_w[0] = 8'hC1;
    mosi_w[1] = 8'hC2;
    mosi_w[2] = 8'hC3;
    run(3, 0);

    // Nothing loaded: zeros on MISO and one underrun.
    mosi_w[0] = 8'h77;
    run(1, 0);

    // Consumer stalled across two frames.
    set_rx_ready(1'b0);
    push_tx(8'h81);
    push_tx(8'h82);
    repeat (4) @(negedge pclk);
    mosi_w[0] = 8'h01;
    mosi_w[1] = 8'h02;
    run(2, 0);
    check_eq("ovf_rx_data", rxd[3], 8'h01);

    // SS raised after 5 bits; RX must keep its unread word.
    mosi_w[0] = 8'hFF;
    run(0, 5);

    // Recovery frame after the abort.
    set_rx_ready(1'b1);
    push_tx(8'hC3);
    repeat (4) @(negedge pclk);
    mosi_w[0] = 8'h5A;
    run(1, 0);

    // Randomised bursts.
    for (int it = 0; it < 10; it++) begin
      int nfr, part, ntx;
      nfr  = $urandom_range(1, 3);
      part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      ntx  = $urandom_range(0, nfr + 1);
      for (int i = 0; i < 4; i++) mosi_w[i] = 8'($urandom);
      set_rx_ready(1'($urandom_range(0, 1)));
      for (int i = 0; i < ntx; i++) push_tx(8'($urandom));
      repeat (4) @(negedge pclk);
      run(nfr, part);
    end

    // Reset in the middle of a frame.
    set_rx_ready(1'b1);
    check_eq("pre_reset_rx", got_q.size(), exp_got.size());
    got_q.delete();
    exp_got.delete();
    push_tx(8'h96);
    repeat (4) @(negedge pclk);
    if (mq.size() == 0) exp_und++;
    ss = 1'b0;
    repeat (H) @(negedge pclk);
    for (int b = 0; b < 3; b++) do_bit(0, b, b[0]);
    presetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge pclk);
    ss = 1'b1;
    sclk_base = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    mq.delete();
    feed_q.delete();
    exp_pend = 1'b0;
    repeat (4) @(negedge pclk);
    check_eq("midreset_underruns", n_und, exp_und);
    check_eq("midreset_overflows", n_ovf, exp_ovf);
    check_eq("midreset_aborts", n_abt, exp_abt);
    got_q.delete();

    push_tx(8'h3E);
    repeat (4) @(negedge pclk);
    mosi_w[0] = 8'hE3;
    run(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
